// File: rtl/display_driver_bcm.sv
// HUB75-style scan controller with binary-coded-modulation bit planes.
// It also provides latched global brightness and a frame-boundary buffer flip handshake.
module display_driver_bcm #(
  parameter int ROWS               = 16,
  parameter int COLUMNS            = 64,
  parameter int PLANES             = 8,
  parameter int BASE_HOLD          = 4,
  parameter int LATCH_DELAY        = 4,
  parameter int BW                 = 4,
  parameter int DEFAULT_BRIGHTNESS = (1 << BW) - 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
  localparam int PLW = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BW-1:0]  brightness,
  input  logic           flip_req,
  output logic [RW-1:0]  row,
  output logic [CW-1:0]  column,
  output logic [PLW-1:0] plane,
  output logic           oclk,
  output logic           lat,
  output logic           oe,
  output logic           flip_ack,
  output logic           frame_end
);

  // Wide enough for BASE_HOLD << (PLANES-1) scaled by up to 2^BW.
  localparam int HW  = $clog2(BASE_HOLD) + PLANES + BW;
  localparam int LDW = $clog2(LATCH_DELAY + 1);

  typedef enum logic [3:0] {
    ADDR, VALUE, ENCODE, COL_H, COL_L, LAT, LAT_WAIT, HOLD, STEP
  } state_t;

  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [LDW-1:0]  wait_cnt;
  logic [BW-1:0]   bright_q;
  logic [HW-1:0]   hold_len;
  logic [HW-1:0]   on_time;
  logic [CW-1:0]   next_col;
  logic            last_slot;

  always_comb begin
    hold_len  = HW'(BASE_HOLD) << plane;
    on_time   = (hold_len * (HW'(bright_q) + HW'(1))) >> BW;
    next_col  = (column == CW'(COLUMNS - 1)) ? '0 : column + CW'(1);
    last_slot = (row == RW'(ROWS - 1)) && (plane == PLW'(PLANES - 1));
  end

  // Outputs are registered for the state being entered, so they line up with the state cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ADDR;
      row       <= '0;
      column    <= '0;
      plane     <= '0;
      oclk      <= 1'b0;
      lat       <= 1'b1;
      oe        <= 1'b1;
      flip_ack  <= 1'b0;
      frame_end <= 1'b0;
      bright_q  <= BW'(DEFAULT_BRIGHTNESS);
      h_cnt     <= '0;
      wait_cnt  <= '0;
    end else begin
      oclk      <= 1'b0;
      lat       <= 1'b1;
      oe        <= 1'b1;
      flip_ack  <= 1'b0;
      frame_end <= 1'b0;
      case (state)
        ADDR:  state <= VALUE;
        VALUE: state <= ENCODE;
        ENCODE: begin
          column <= next_col;
          oclk   <= 1'b1;
          state  <= COL_H;
        end
        COL_H: state <= COL_L;
        // Column wrapped back to 0 means all COLUMNS bits have been clocked out.
        COL_L: begin
          if (column == '0) begin
            lat   <= 1'b0;
            state <= LAT;
          end else begin
            column <= next_col;
            oclk   <= 1'b1;
            state  <= COL_H;
          end
        end
        LAT: begin
          wait_cnt <= '0;
          state    <= LAT_WAIT;
        end
        LAT_WAIT: begin
          if (wait_cnt == LDW'(LATCH_DELAY - 1)) begin
            h_cnt <= '0;
            oe    <= (on_time == '0);
            state <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + LDW'(1);
          end
        end
        HOLD: begin
          if (h_cnt == hold_len - HW'(1)) begin
            frame_end <= last_slot;
            flip_ack  <= last_slot & flip_req;
            if (last_slot) bright_q <= brightness;
            state <= STEP;
          end else begin
            h_cnt <= h_cnt + HW'(1);
            oe    <= ((h_cnt + HW'(1)) >= on_time);
          end
        end
        // Addresses move on leaving STEP so both neighbouring cycles have oe high.
        STEP: begin
          if (plane == PLW'(PLANES - 1)) begin
            plane <= '0;
            row   <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
          end else begin
            plane <= plane + PLW'(1);
          end
          state <= ADDR;
        end
        default: state <= ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_display_driver_bcm.sv
// Directed bench for display_driver_bcm: records three frames after reset and checks slot timing.
// It also covers brightness latching, the flip handshake, the panel protocol and a mid-HOLD reset.
module tb_display_driver_bcm;

  localparam int ROWS = 2, COLUMNS = 4, PLANES = 2, BASE_HOLD = 4, LATCH_DELAY = 2, BW = 4;
  localparam int NREC = 330;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] brightness;
  logic       flip_req;
  logic [0:0] row;
  logic [1:0] column;
  logic [0:0] plane;
  logic       oclk, lat, oe, flip_ack, frame_end;

  display_driver_bcm #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .PLANES(PLANES), .BASE_HOLD(BASE_HOLD),
    .LATCH_DELAY(LATCH_DELAY), .BW(BW), .DEFAULT_BRIGHTNESS(15)
  ) dut (
    .clk(clk), .rst(rst), .brightness(brightness), .flip_req(flip_req),
    .row(row), .column(column), .plane(plane), .oclk(oclk), .lat(lat),
    .oe(oe), .flip_ack(flip_ack), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       oe_a [NREC], lat_a [NREC], oclk_a [NREC], fe_a [NREC], ack_a [NREC];
  logic [0:0] row_a [NREC], plane_a [NREC];
  logic [1:0] col_a [NREC];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Input changes keyed to the cycle index since reset release (index 0 is the first ADDR).
  task automatic applyStimulus(input int i);
    case (i)
      40:  brightness = 4'd7;
      114: flip_req   = 1'b1;
      120: brightness = 4'd0;
      170: flip_req   = 1'b0;
      200: brightness = 4'd15;
      260: brightness = 4'd7;
      default: ;
    endcase
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_oe"}, 32'(oe), 1);
    checkOutput({pfx, "_lat"}, 32'(lat), 1);
    checkOutput({pfx, "_oclk"}, 32'(oclk), 0);
    checkOutput({pfx, "_flip_ack"}, 32'(flip_ack), 0);
    checkOutput({pfx, "_frame_end"}, 32'(frame_end), 0);
    checkOutput({pfx, "_row"}, 32'(row), 0);
    checkOutput({pfx, "_column"}, 32'(column), 0);
    checkOutput({pfx, "_plane"}, 32'(plane), 0);
  endtask

  int starts [12];
  int hlen   [12];
  int on_exp [12];
  logic [1:0] code_exp [12];

  initial begin
    rst        = 1'b1;
    brightness = 4'd15;
    flip_req   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset state");
    checkResetValues("reset");
    rst = 1'b0;

    for (int i = 0; i < NREC; i++) begin
      if (i > 0) @(negedge clk);
      oe_a[i]    = oe;
      lat_a[i]   = lat;
      oclk_a[i]  = oclk;
      fe_a[i]    = frame_end;
      ack_a[i]   = flip_ack;
      row_a[i]   = row;
      plane_a[i] = plane;
      col_a[i]   = column;
      applyStimulus(i);
    end

    // Hand-derived slot layout: lengths 19/23, frames of 84, on-times 4/8 then 2/4 then 0/0.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = 4 * f + k;
        starts[s]   = 84 * f + ((k == 0) ? 0 : (k == 1) ? 19 : (k == 2) ? 42 : 61);
        hlen[s]     = (k % 2 == 1) ? 8 : 4;
        code_exp[s] = 2'(k);
        on_exp[s]   = (f == 0) ? hlen[s] : (f == 1) ? hlen[s] / 2 : 0;
      end
    end

    $display("[TB] slot timing over three frames");
    for (int s = 0; s < 12; s++) begin
      int oclk_n, lat_n, lat_first, oe_n, oe_first, code_bad, idx;
      oclk_n = 0; lat_n = 0; lat_first = -1; oe_n = 0; oe_first = -1; code_bad = 0;
      for (int j = 0; j < 15 + hlen[s]; j++) begin
        idx = starts[s] + j;
        if (oclk_a[idx] === 1'b1) oclk_n++;
        if (lat_a[idx] === 1'b0) begin
          lat_n++;
          if (lat_first < 0) lat_first = j;
        end
        if (oe_a[idx] === 1'b0) begin
          oe_n++;
          if (oe_first < 0) oe_first = j;
        end
        if ({row_a[idx], plane_a[idx]} !== code_exp[s]) code_bad++;
      end
      checkOutput($sformatf("slot%0d_oclk_pulses", s), 32'(oclk_n), 4);
      checkOutput($sformatf("slot%0d_lat_cycles", s), 32'(lat_n), 1);
      checkOutput($sformatf("slot%0d_lat_offset", s), 32'(lat_first), 11);
      checkOutput($sformatf("slot%0d_oe_low_cycles", s), 32'(oe_n), 32'(on_exp[s]));
      checkOutput($sformatf("slot%0d_oe_first_low", s), 32'(oe_first),
                  32'((on_exp[s] > 0) ? 14 : -1));
      checkOutput($sformatf("slot%0d_addr_span", s), 32'(code_bad), 0);
    end

    $display("[TB] column sequence");
    checkOutput("col_first_oclk", 32'(col_a[3]), 1);
    checkOutput("col_last_oclk", 32'(col_a[9]), 0);
    checkOutput("col_at_lat", 32'(col_a[11]), 0);

    $display("[TB] frame_end and flip handshake");
    begin
      int fe_n, ack_n, vio;
      fe_n = 0; ack_n = 0; vio = 0;
      for (int i = 0; i < 252; i++) begin
        if (fe_a[i] === 1'b1) fe_n++;
        if (ack_a[i] === 1'b1) ack_n++;
      end
      checkOutput("frame_end_count", 32'(fe_n), 3);
      checkOutput("frame_end_f0", 32'(fe_a[83]), 1);
      checkOutput("frame_end_f1", 32'(fe_a[167]), 1);
      checkOutput("frame_end_f2", 32'(fe_a[251]), 1);
      checkOutput("flip_ack_count", 32'(ack_n), 1);
      checkOutput("flip_ack_at_frame_end", 32'(ack_a[167]), 1);

      // Protocol: addresses move only with oe high on both sides; oe low never meets lat low or oclk high.
      for (int i = 1; i < 252; i++) begin
        if ({row_a[i], plane_a[i]} !== {row_a[i-1], plane_a[i-1]} &&
            (oe_a[i] !== 1'b1 || oe_a[i-1] !== 1'b1)) vio++;
        if (oe_a[i] === 1'b0 && (lat_a[i] !== 1'b1 || oclk_a[i] !== 1'b0)) vio++;
      end
      checkOutput("protocol_violations", 32'(vio), 0);
    end

    $display("[TB] reset during HOLD of row 1 plane 1");
    checkOutput("pre_reset_row", 32'(row_a[NREC-1]), 1);
    checkOutput("pre_reset_plane", 32'(plane_a[NREC-1]), 1);
    checkOutput("pre_reset_oe", 32'(oe_a[NREC-1]), 0);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midrst");
    rst = 1'b0;
    begin
      int fe_at, oe_lows;
      fe_at = 0; oe_lows = 0;
      for (int n = 1; n <= 200 && fe_at == 0; n++) begin
        if (n > 1) @(negedge clk);
        if (oe === 1'b0) oe_lows++;
        if (frame_end === 1'b1) fe_at = n;
      end
      checkOutput("restart_frame_end_cycle", 32'(fe_at), 84);
      checkOutput("restart_oe_low_total", 32'(oe_lows), 24);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_driver_bcm.md
Name: display_driver_bcm

Overview:
- Next-generation HUB75-style scan controller driving one panel.
- Adds binary-coded-modulation (BCM) bit-plane sequencing, parametrised geometry, a configurable latch settle time, scaled global brightness and a frame-buffer flip handshake.
- Sits between the frame-buffer BRAM/bit-plane encoder (fed by the row/column/plane addresses) and the panel control pins.

Parameters:
- ROWS, 16, addressable scan rows (≥2).
- COLUMNS, 64, shift-register bits per row (≥2).
- PLANES, 8, colour bit depth, i.e. the number of BCM planes (≥1).
- BASE_HOLD, 4, display cycles for plane 0; plane p holds for BASE_HOLD<<p cycles (power of 2, ≥1).
- LATCH_DELAY, 4, settle cycles after the latch pulse before output-enable (≥1).
- BW, 4, brightness width.
- DEFAULT_BRIGHTNESS, 2^BW-1, brightness after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- brightness  in  BW  global brightness; sampled only at frame end.
- flip_req  in  1  level; the producer has a new buffer ready.
- row  out  clog2(ROWS)  row address to the panel and BRAM.
- column  out  clog2(COLUMNS)  column address to the BRAM.
- plane  out  clog2(PLANES) (min 1)  bit-plane select to the encoder.
- oclk  out  1  panel shift clock.
- lat  out  1  panel latch, active low.
- oe  out  1  panel output enable, active low.
- flip_ack  out  1  one-cycle pulse; swap buffers now.
- frame_end  out  1  one-cycle pulse at the end of every frame.

Behaviour:
- Reset values:
  - oe=1, lat=1, oclk=0, flip_ack=0, frame_end=0.
  - row=0, column=0, plane=0.
  - brightness register=DEFAULT_BRIGHTNESS; state=ADDR.
  - rst mid-operation aborts immediately to these values, with no partial latch or oe pulse.
- Slot order: for each row 0..ROWS-1, run planes 0..PLANES-1, then the next row.
- States per slot. Defaults are oe=1, lat=1, oclk=0 unless stated.
  - ADDR (1 cycle): addresses propagate.
  - VALUE (1 cycle): BRAM read.
  - ENCODE (1 cycle): column advances.
  - COL_H (oclk=1) and COL_L (oclk=0) alternate. Exactly COLUMNS oclk pulses per slot.
  - Column increments at ENCODE and each COL_L, wrapping COLUMNS-1→0. COL_L with column==0 exits to LAT.
  - LAT: lat=0 for 1 cycle.
  - LAT_WAIT: LATCH_DELAY cycles.
  - HOLD: H=BASE_HOLD<<plane cycles, counter h=0..H-1. oe=0 iff h < ON, where ON=(H*(b+1))>>BW and b is the latched brightness.
  - STEP (1 cycle): plane++. On plane wrap, plane=0 and row++. On row wrap, row=0 and frame end.
- Slot length = 3 + 2*COLUMNS + 1 + LATCH_DELAY + H + 1 cycles.
- row and plane change only in STEP, while oe=1. oe is never low outside HOLD.
- ON arithmetic: full-precision product, width clog2(BASE_HOLD)+PLANES+BW. No overflow; ON ≤ H always.
- Frame end (STEP of last row, last plane):
  - frame_end=1.
  - The brightness register loads the brightness input.
  - If flip_req=1 the same cycle: flip_ack=1 for exactly that cycle. Otherwise flip_ack=0 and flip_req remains pending.
  - flip_ack is never asserted outside this cycle, so a flip_req raised mid-frame waits for the frame end.
- Brightness changes mid-frame have no effect until the frame end.

Test Plan:
Parameters for all scenarios: ROWS=2, COLUMNS=4, PLANES=2, BASE_HOLD=4, LATCH_DELAY=2, BW=4.
1. Reset release, brightness held 15 → exactly 4 oclk pulses per slot. Slot lengths 19 (plane 0) and 23 (plane 1); frame_end every 84 cycles. oe low for 4 then 8 consecutive cycles.
2. DEFAULT 15, brightness input=7 before the first frame end → frame 1 has on-times 4/8. From frame 2: plane 0 oe low 2 cycles, plane 1 oe low 4 cycles, oe starting at h=0.
3. brightness=0 latched → oe stays 1 for the whole frame, while oclk/lat timing is unchanged.
4. flip_req raised at cycle 30 of a frame and held → flip_ack is a single pulse coincident with frame_end at cycle 84, and none earlier.
5. Protocol checker over 3 frames → row/plane change only while oe=1; lat low exactly 1 cycle per slot; oe low never overlaps lat=0 or oclk=1.
6. rst asserted during the HOLD of row 1, plane 1 → next cycle all outputs at reset values. The full sequence restarts at row 0, plane 0 and the next frame_end arrives 84 cycles after rst deasserts.
